// File: rtl/riscvibe_pkg.sv
// Shared RISC-V core definitions: funct3 memory width codes and the
// data-memory port arbiter owner/lock-state enums.
package riscvibe_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} arb_owner_t;

    typedef enum logic {ARB_UNLOCKED, ARB_LOCKED} arb_lock_state_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the core load/store path and the
// debug/loader port: fixed CORE priority, DBG starvation guard and DBG burst lock.
module dmem_port_arbiter
    import riscvibe_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [31:0]       core_req_wdata,
    input  logic              core_req_we,
    input  logic [2:0]        core_req_width,
    output logic              core_rsp_valid,
    output logic [31:0]       core_rsp_rdata,

    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [31:0]       dbg_req_wdata,
    input  logic              dbg_req_we,
    input  logic [2:0]        dbg_req_width,
    input  logic              dbg_req_lock,
    output logic              dbg_rsp_valid,
    output logic [31:0]       dbg_rsp_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_width,
    input  logic [31:0]       mem_rdata,

    output logic              dbg_locked
);

    localparam int unsigned    CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam bit             GUARD_EN   = (MAX_WAIT != 0);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    arb_lock_state_t  lock_state_q;
    arb_owner_t       rsp_owner_q;
    logic [CNT_W-1:0] wait_cnt_q;

    logic active_lock;
    logic starve;
    logic grant_core;
    logic grant_dbg;

    // A LOCKED state with DBG no longer valid is an abort: treat the port as
    // unlocked already this cycle so CORE can be granted immediately.
    always_comb begin
        active_lock    = (lock_state_q == ARB_LOCKED) && dbg_req_valid;
        starve         = GUARD_EN && (wait_cnt_q >= WAIT_LIMIT);
        core_req_ready = rst_n && !active_lock && !(starve && dbg_req_valid);
        dbg_req_ready  = rst_n && (active_lock || starve || !core_req_valid);
        grant_core     = core_req_valid && core_req_ready;
        grant_dbg      = dbg_req_valid && dbg_req_ready;
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_width = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (grant_core) begin
            mem_addr  = core_req_addr;
            mem_wdata = core_req_wdata;
            mem_width = core_req_width;
            mem_read  = !core_req_we;
            mem_write = core_req_we;
        end else if (grant_dbg) begin
            mem_addr  = dbg_req_addr;
            mem_wdata = dbg_req_wdata;
            mem_width = dbg_req_width;
            mem_read  = !dbg_req_we;
            mem_write = dbg_req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_state_q <= ARB_UNLOCKED;
            wait_cnt_q   <= '0;
            rsp_owner_q  <= OWN_NONE;
        end else begin
            case (lock_state_q)
                ARB_UNLOCKED: if (grant_dbg && dbg_req_lock) lock_state_q <= ARB_LOCKED;
                ARB_LOCKED:   if (!dbg_req_valid || (grant_dbg && !dbg_req_lock))
                                  lock_state_q <= ARB_UNLOCKED;
                default:      lock_state_q <= ARB_UNLOCKED;
            endcase

            if (!dbg_req_valid || grant_dbg)
                wait_cnt_q <= '0;
            else if (wait_cnt_q != CNT_MAX)
                wait_cnt_q <= wait_cnt_q + 1'b1;

            if (grant_core && !core_req_we)
                rsp_owner_q <= OWN_CORE;
            else if (grant_dbg && !dbg_req_we)
                rsp_owner_q <= OWN_DBG;
            else
                rsp_owner_q <= OWN_NONE;
        end
    end

    always_comb begin
        core_rsp_valid = rst_n && (rsp_owner_q == OWN_CORE);
        dbg_rsp_valid  = rst_n && (rsp_owner_q == OWN_DBG);
        core_rsp_rdata = core_rsp_valid ? mem_rdata : 32'h0;
        dbg_rsp_rdata  = dbg_rsp_valid ? mem_rdata : 32'h0;
        dbg_locked     = rst_n && (lock_state_q == ARB_LOCKED);
    end

endmodule
